// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite attribute RAM consumers: field layout,
// the height-code helper, the line descriptor and the scanner state encoding.
package sprite_pkg;

    localparam int X_LSB     = 0;
    localparam int X_MSB     = 9;
    localparam int VFLIP_BIT = 10;
    localparam int HFLIP_BIT = 11;
    localparam int PAL_LSB   = 12;
    localparam int PAL_MSB   = 15;
    localparam int Y_LSB     = 16;
    localparam int Y_MSB     = 24;
    localparam int MODE_BIT  = 25;
    localparam int Z_LSB     = 26;
    localparam int Z_MSB     = 27;
    localparam int H_LSB     = 28;
    localparam int H_MSB     = 29;
    localparam int W_LSB     = 30;
    localparam int W_MSB     = 31;
    localparam int ADDR_LSB  = 32;
    localparam int ADDR_MSB  = 47;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_EMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [9:0]  x;
        logic [5:0]  row;
        logic        hflip;
        logic [3:0]  pal;
        logic        mode;
        logic [1:0]  z;
        logic [1:0]  width;
        logic [15:0] addr;
    } desc_t;

    // 8/16/32/64 pixel rows for height codes 0..3
    function automatic logic [6:0] height_px(input logic [1:0] code);
        return 7'd8 << code;
    endfunction

endpackage

// File: rtl/sprite_line_scanner_if.sv
// Descriptor stream from the line scanner to the sprite line renderer, plus
// the end-of-scan status (done pulse, hit count, overflow flag).
interface sprite_line_scanner_if;

    logic        desc_valid_o;
    logic        desc_ready_i;
    logic [7:0]  desc_idx_o;
    logic [9:0]  desc_x_o;
    logic [5:0]  desc_row_o;
    logic        desc_hflip_o;
    logic [3:0]  desc_pal_o;
    logic        desc_mode_o;
    logic [1:0]  desc_z_o;
    logic [1:0]  desc_width_o;
    logic [15:0] desc_addr_o;
    logic        done_o;
    logic [7:0]  hit_count_o;
    logic        overflow_o;

    modport master (
        output desc_valid_o, desc_idx_o, desc_x_o, desc_row_o, desc_hflip_o,
               desc_pal_o, desc_mode_o, desc_z_o, desc_width_o, desc_addr_o,
               done_o, hit_count_o, overflow_o,
        input  desc_ready_i
    );

    modport slave (
        input  desc_valid_o, desc_idx_o, desc_x_o, desc_row_o, desc_hflip_o,
               desc_pal_o, desc_mode_o, desc_z_o, desc_width_o, desc_addr_o,
               done_o, hit_count_o, overflow_o,
        output desc_ready_i
    );

endinterface

// File: rtl/sprite_attr_decode.sv
// Combinational decode of one 48-bit sprite attribute entry against a display
// line: field extraction, vertical hit test and flip-adjusted row.
module sprite_attr_decode
    import sprite_pkg::*;
(
    input  logic [47:0] entry,
    input  logic [8:0]  line,
    input  logic [7:0]  idx,
    output logic        hit,
    output desc_t       desc
);

    logic [8:0] y;
    logic [8:0] d;
    logic [6:0] hgt;

    always_comb begin
        y   = entry[Y_MSB:Y_LSB];
        hgt = height_px(entry[H_MSB:H_LSB]);
        // 9-bit wrap lets sprites near y=511 continue onto the top lines
        d   = line - y;
        hit = (entry[Z_MSB:Z_LSB] != 2'd0) && (d < {2'b00, hgt});

        desc.idx   = idx;
        desc.x     = entry[X_MSB:X_LSB];
        desc.row   = entry[VFLIP_BIT] ? (6'(hgt - 7'd1) - d[5:0]) : d[5:0];
        desc.hflip = entry[HFLIP_BIT];
        desc.pal   = entry[PAL_MSB:PAL_LSB];
        desc.mode  = entry[MODE_BIT];
        desc.z     = entry[Z_MSB:Z_LSB];
        desc.width = entry[W_MSB:W_LSB];
        desc.addr  = entry[ADDR_MSB:ADDR_LSB];
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line walk of the sprite attribute RAM, emitting one descriptor per
// sprite on the line. Optional overflow reporting: SPRITE_LINE_OVERFLOW_EN.
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 128,
    parameter int MAX_PER_LINE = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   line_start_i,
    input  logic [8:0]             line_idx_i,
    output logic                   rd_en_o,
    output logic [7:0]             rd_addr_o,
    input  logic [47:0]            rd_data_i,
    sprite_line_scanner_if.master  desc_if
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_SPRITES - 1);
    localparam logic [7:0] MAX_Q    = 8'(MAX_PER_LINE);

    state_t     state, state_d;
    logic [8:0] line_q;
    logic [7:0] idx, idx_d;
    logic [7:0] count, count_d, count_inc;
    logic [7:0] hit_count_q;
    desc_t      desc_q, dec_desc;
    logic       dec_hit;
    logic       load_desc;
    logic       cap_reached;

    sprite_attr_decode u_decode (
        .entry (rd_data_i),
        .line  (line_q),
        .idx   (idx),
        .hit   (dec_hit),
        .desc  (dec_desc)
    );

`ifdef SPRITE_LINE_OVERFLOW_EN
    logic set_ovf;
    logic overflow_q;
    // Keep scanning past the cap so the first extra hit can be flagged
    assign cap_reached = 1'b0;
`else
    assign cap_reached = (count_inc == MAX_Q);
`endif

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        count_d   = count;
        count_inc = count + 8'd1;
        load_desc = 1'b0;
`ifdef SPRITE_LINE_OVERFLOW_EN
        set_ovf   = 1'b0;
`endif
        case (state)
            S_IDLE: ;
            S_READ: state_d = S_EVAL;
            S_EVAL: begin
                if (dec_hit && (count < MAX_Q)) begin
                    load_desc = 1'b1;
                    state_d   = S_EMIT;
                end else begin
`ifdef SPRITE_LINE_OVERFLOW_EN
                    if (dec_hit) set_ovf = 1'b1;
`endif
                    if (idx == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + 8'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_EMIT: begin
                if (desc_if.desc_ready_i) begin
                    count_d = count_inc;
                    if ((idx == LAST_IDX) || cap_reached) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + 8'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new line always wins, including over a same-cycle transfer
        if (line_start_i) begin
            state_d = S_READ;
            idx_d   = 8'd0;
            count_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q      <= '0;
            idx         <= '0;
            count       <= '0;
            hit_count_q <= '0;
            desc_q      <= '0;
        end else begin
            idx   <= idx_d;
            count <= count_d;
            if (line_start_i)    line_q      <= line_idx_i;
            if (line_start_i)    hit_count_q <= '0;
            else if (state == S_DONE) hit_count_q <= count;
            if (load_desc)       desc_q      <= dec_desc;
        end
    end

`ifdef SPRITE_LINE_OVERFLOW_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          overflow_q <= 1'b0;
        else if (line_start_i) overflow_q <= 1'b0;
        else if (set_ovf)      overflow_q <= 1'b1;
    end
    assign desc_if.overflow_o = overflow_q;
`else
    assign desc_if.overflow_o = 1'b0;
`endif

    assign rd_en_o   = (state == S_READ);
    assign rd_addr_o = rd_en_o ? idx : 8'd0;

    assign desc_if.desc_valid_o = (state == S_EMIT);
    assign desc_if.done_o       = (state == S_DONE);
    assign desc_if.hit_count_o  = (state == S_DONE) ? count : hit_count_q;
    assign desc_if.desc_idx_o   = desc_q.idx;
    assign desc_if.desc_x_o     = desc_q.x;
    assign desc_if.desc_row_o   = desc_q.row;
    assign desc_if.desc_hflip_o = desc_q.hflip;
    assign desc_if.desc_pal_o   = desc_q.pal;
    assign desc_if.desc_mode_o  = desc_q.mode;
    assign desc_if.desc_z_o     = desc_q.z;
    assign desc_if.desc_width_o = desc_q.width;
    assign desc_if.desc_addr_o  = desc_q.addr;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner: directed scenarios plus random
// RAM contents compared against a per-line list model of expected descriptors.
module tb_sprite_line_scanner;

    localparam int NS   = 128;
    localparam int MAXP = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [8:0]  line_idx = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [47:0] rd_data = '0;
    logic [47:0] ram [256];

    sprite_line_scanner_if dif ();

    sprite_line_scanner #(.NUM_SPRITES(NS), .MAX_PER_LINE(MAXP)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .line_start_i (line_start),
        .line_idx_i   (line_idx),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .desc_if      (dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int checks = 0, passed = 0, fails = 0;
    logic [49:0] exp_q [$];
    logic [49:0] obs_q [$];
    int exp_cnt;
    bit exp_ovf;
    int last_hits;
    logic last_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] obs_pack();
        return {dif.desc_idx_o, dif.desc_x_o, dif.desc_row_o, dif.desc_hflip_o, dif.desc_pal_o,
                dif.desc_mode_o, dif.desc_z_o, dif.desc_width_o, dif.desc_addr_o};
    endfunction

    function automatic logic [47:0] mk(int x, int y, bit vf, bit hf, int pal, bit mode,
                                       int z, int h, int w, int addr);
        logic [47:0] r;
        r = '0;
        r[9:0] = 10'(x);   r[10] = vf;       r[11] = hf;       r[15:12] = 4'(pal);
        r[24:16] = 9'(y);  r[25] = mode;     r[27:26] = 2'(z); r[29:28] = 2'(h);
        r[31:30] = 2'(w);  r[47:32] = 16'(addr);
        return r;
    endfunction

    function automatic void clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = '0;
    endfunction

    // Reference: walk the entries in order, keep the first MAXP hits
    function automatic void build_model(input int line);
        exp_q.delete();
        exp_cnt = 0;
        exp_ovf = 0;
        for (int e = 0; e < NS; e++) begin
            logic [47:0] w;
            int y, h, d, row;
            w = ram[e];
            y = int'(w[24:16]);
            h = 8 * (1 << int'(w[29:28]));
            d = (line - y + 512) % 512;
            if (w[27:26] != 2'd0 && d < h) begin
                if (exp_cnt < MAXP) begin
                    row = w[10] ? (h - 1 - d) : d;
                    exp_q.push_back({8'(e), w[9:0], 6'(row), w[11], w[15:12], w[25],
                                     w[27:26], w[31:30], w[47:32]});
                    exp_cnt++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
    endfunction

    function automatic logic exp_overflow();
`ifdef SPRITE_LINE_OVERFLOW_EN
        return exp_ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic start_line(input int line);
        @(negedge clk);
        line_start = 1'b1;
        line_idx   = 9'(line);
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_valid"},   dif.desc_valid_o, 0);
        check({tag, "_done"},    dif.done_o, 0);
        check({tag, "_hits"},    dif.hit_count_o, 0);
        check({tag, "_ovf"},     dif.overflow_o, 0);
        check({tag, "_desc"},    obs_pack(), 0);
    endtask

    // stall < 0: random ready; otherwise ready low for 'stall' valid cycles per descriptor.
    // first_vld >= 0: cycle (0 = READ of entry 0) at which valid must first rise.
    task automatic collect(input int line, input int stall, input int first_vld);
        bit done_seen = 0, held = 0, r;
        logic [49:0] held_v = '0;
        int waitc = 0;
        build_model(line);
        obs_q.delete();
        last_hits = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (first_vld >= 0 && cyc == 0) check("lat_rd_en", {rd_en, rd_addr}, {1'b1, 8'd0});
            if (first_vld >= 0 && cyc == first_vld - 1) check("lat_early", dif.desc_valid_o, 0);
            if (first_vld >= 0 && cyc == first_vld) check("lat_valid", dif.desc_valid_o, 1);
            if (dif.done_o) begin
                done_seen = 1;
                break;
            end
            if (held) begin
                check("valid_held", dif.desc_valid_o, 1);
                check("desc_stable", obs_pack(), held_v);
                held = 0;
            end
            if (dif.desc_valid_o) begin
                r = (stall < 0) ? ($urandom_range(0, 2) != 0) : (waitc >= stall);
                dif.desc_ready_i = r;
                if (r) begin
                    obs_q.push_back(obs_pack());
                    waitc = 0;
                end else begin
                    held   = 1;
                    held_v = obs_pack();
                    waitc++;
                end
            end else begin
                dif.desc_ready_i = 1'b0;
            end
            @(negedge clk);
        end
        dif.desc_ready_i = 1'b0;
        check("done_seen", done_seen, 1);
        if (done_seen) begin
            last_hits = int'(dif.hit_count_o);
            last_ovf  = dif.overflow_o;
            check("hit_count", dif.hit_count_o, 64'(exp_cnt));
            check("overflow", dif.overflow_o, exp_overflow());
            check("n_desc", obs_q.size(), exp_q.size());
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                check($sformatf("desc%0d", i), obs_q[i], exp_q[i]);
            @(negedge clk);
            check("done_pulse", dif.done_o, 0);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && !dif.desc_valid_o; i++) begin
            check("no_early_done", dif.done_o, 0);
            @(negedge clk);
        end
        check("wait_valid", dif.desc_valid_o, 1);
    endtask

    initial begin
        dif.desc_ready_i = 1'b0;
        clear_ram();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic hit, latency with one non-hit entry in front
        ram[1] = mk(60, 3, 0, 0, 0, 0, 1, 1, 2, 'h1000);
        start_line(3);
        collect(3, 0, 4);
        check("tp1_hits", last_hits, 1);
        if (obs_q.size() > 0)
            check("tp1_desc", obs_q[0], {8'd1, 10'd60, 6'd0, 1'b0, 4'd0, 1'b0, 2'd1, 2'd2, 16'h1000});

        start_line(18);
        collect(18, 0, -1);
        if (obs_q.size() > 0) check("tp2_row15", obs_q[0][31:26], 15);
        start_line(19);
        collect(19, 0, -1);
        check("tp2_miss", last_hits, 0);
        ram[1] = mk(60, 3, 1, 0, 0, 0, 1, 1, 2, 'h1000);
        start_line(3);
        collect(3, 0, -1);
        if (obs_q.size() > 0) check("tp2_vflip_row", obs_q[0][31:26], 15);

        // Vertical wrap and z=0 transparency
        ram[1] = mk(100, 510, 0, 1, 5, 1, 2, 0, 1, 'h2222);
        start_line(2);
        collect(2, -1, -1);
        if (obs_q.size() > 0) check("tp3_wrap_row", obs_q[0][31:26], 4);
        ram[1] = mk(100, 510, 0, 1, 5, 1, 0, 0, 1, 'h2222);
        start_line(2);
        collect(2, 0, -1);
        check("tp3_z0", last_hits, 0);

        // Two hits with backpressure
        ram[1]  = mk(60, 3, 0, 0, 0, 0, 1, 1, 2, 'h1000);
        ram[10] = mk(200, 0, 0, 0, 3, 0, 3, 2, 0, 'h0abc);
        start_line(3);
        collect(3, 5, -1);
        check("tp4_hits", last_hits, 2);
        if (obs_q.size() == 2) check("tp4_order", {obs_q[0][49:42], obs_q[1][49:42]}, {8'd1, 8'd10});

        // Restart during EMIT without a transfer
        start_line(3);
        wait_valid();
        start_line(3);
        check("rs_valid", dif.desc_valid_o, 0);
        check("rs_read", {rd_en, rd_addr}, {1'b1, 8'd0});
        check("rs_done", dif.done_o, 0);
        collect(3, 0, -1);
        check("rs_hits", last_hits, 2);

        // Restart coinciding with a transfer: count restarts from zero
        start_line(3);
        wait_valid();
        dif.desc_ready_i = 1'b1;
        line_start = 1'b1;
        line_idx   = 9'd3;
        @(negedge clk);
        line_start = 1'b0;
        dif.desc_ready_i = 1'b0;
        check("rs2_valid", dif.desc_valid_o, 0);
        collect(3, 0, -1);
        check("rs2_hits", last_hits, 2);

        // Reset in the middle of EMIT
        start_line(3);
        wait_valid();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", {rd_en, dif.done_o, dif.desc_valid_o}, 0);
        end

        // Cap at MAX_PER_LINE
        clear_ram();
        for (int e = 0; e < 70; e++) ram[e] = mk(e, 0, 0, 0, 0, 0, 1, 3, 0, e);
        start_line(5);
        collect(5, 0, -1);
        check("cap_count", obs_q.size(), MAXP);
`ifdef SPRITE_LINE_OVERFLOW_EN
        check("cap_ovf", last_ovf, 1);
`else
        check("cap_ovf", last_ovf, 0);
`endif

        // Random attribute tables, lines and backpressure
        for (int rnd = 0; rnd < 8; rnd++) begin
            int ln;
            ln = $urandom_range(0, 511);
            clear_ram();
            for (int e = 0; e < NS; e++) begin
                logic [47:0] w;
                w = {16'($urandom), $urandom};
                if ($urandom_range(0, 1) != 0) w[24:16] = 9'(ln - $urandom_range(0, 70));
                ram[e] = w;
            end
            start_line(ln);
            collect(ln, (rnd % 2 == 0) ? -1 : 0, -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_scanner.md
Name: sprite_line_scanner

Overview:
- Read-side consumer of the 256x48 sprite attribute RAM.
- On each display line, walks attribute entries 0..NUM_SPRITES-1 through the RAM's synchronous read port and decodes each entry.
- Emits one descriptor per sprite that intersects the current line, over a valid/ready handshake, to the sprite line renderer.
- Reports completion and the hit count.

Parameters:
- NUM_SPRITES, 128, number of entries scanned (1..256).
- MAX_PER_LINE, 64, maximum descriptors emitted per line (1..255).

Ports:
- clk_i  in  1  single clock; RAM rd_clk_i is driven from the same clock.
- rst_n_i  in  1  asynchronous reset, active low.
- line_start_i  in  1  one-cycle pulse; starts a scan.
- line_idx_i  in  9  display line; sampled on line_start_i.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  8  RAM read address.
- rd_data_i  in  48  RAM read data; valid the cycle after rd_en_o.
- desc_valid_o  out  1  descriptor available.
- desc_ready_i  in  1  renderer accepts the descriptor.
- desc_idx_o  out  8  sprite index.
- desc_x_o  out  10  x position.
- desc_row_o  out  6  row within the sprite, flip applied.
- desc_hflip_o  out  1  horizontal flip.
- desc_pal_o  out  4  palette offset.
- desc_mode_o  out  1  colour mode.
- desc_z_o  out  2  depth.
- desc_width_o  out  2  width code.
- desc_addr_o  out  16  pattern address.
- done_o  out  1  one-cycle pulse at end of scan.
- hit_count_o  out  8  descriptors emitted this line; valid with done_o and held until the next line_start_i.
- overflow_o  out  1  more hits than MAX_PER_LINE; see Optional Feature.

Behaviour:
- Entry field decode:
  - [9:0] x, [10] vflip, [11] hflip, [15:12] palette.
  - [24:16] y, [25] mode, [27:26] z.
  - [29:28] height code, [31:30] width code, [47:32] addr.
  - Height in pixels = 8 << code, i.e. 8/16/32/64.
- Hit test:
  - An entry hits when z != 0 and d = (line - y) mod 512 is less than the height.
  - The subtraction is 9-bit wrapping, so sprites with y near 511 wrap onto lines 0.. .
  - row = vflip ? height-1-d : d.
- State machine: IDLE, READ, EVAL, EMIT, DONE.
  - IDLE: on line_start_i, latch line_idx_i, clear idx and count, go to READ.
  - READ: drive rd_en_o=1 and rd_addr_o=idx; go to EVAL.
  - EVAL: rd_data_i is valid here.
    - If hit and count < MAX_PER_LINE: register the descriptor, go to EMIT.
    - Otherwise, if idx == NUM_SPRITES-1, go to DONE; else increment idx and go to READ.
  - EMIT: desc_valid_o=1 and all desc_* held stable until desc_valid_o && desc_ready_i.
    - On that transfer: increment count; go to DONE if idx == NUM_SPRITES-1 or count reaches MAX_PER_LINE, else increment idx and go to READ.
  - DONE: done_o=1 for one cycle, hit_count_o=count; go to IDLE.
- Latency: line_start_i at cycle T gives rd_en_o at T+1, EVAL at T+2, and earliest desc_valid_o at T+3. Each non-hit entry costs 2 cycles.
- rd_en_o is 0 in every state except READ.
- desc_valid_o never drops without a transfer, except on restart or reset.
- Restart: line_start_i in any non-IDLE state aborts the scan.
  - Drop desc_valid_o, suppress done_o for the aborted line.
  - Relatch the line, clear idx and count, go to READ next cycle.
- Simultaneous transfer and line_start_i: the restart wins, the transfer still counts for the renderer, and count is reset.
- Reset values: all outputs 0, state IDLE, idx 0, count 0.
- Reset asserted mid-scan returns to IDLE immediately, with no done_o.

Optional Feature:
- Macro SPRITE_LINE_OVERFLOW_EN.
- Defined:
  - After count reaches MAX_PER_LINE, scanning continues with no further emission.
  - The first additional hit sets overflow_o; overflow_o is cleared on the next line_start_i.
  - The scan then ends at the last entry.
- Undefined:
  - Scanning stops at MAX_PER_LINE.
  - overflow_o is tied to 0.

Decomposition:
- Shared package sprite_pkg holds:
  - Bit-position constants for every attribute field.
  - The height-code-to-pixels function.
  - The descriptor struct typedef.
  - The state enum.
- One sub-module, sprite_attr_decode: combinational field extraction plus the hit/row computation from entry, line and flip. It is reused by the future collision logic.

Test Plan:
- Entry 1 = {x=60, y=3, h=1, w=2, z=1, addr=0x1000}, line 3 -> one descriptor: idx 1, x 60, row 0, addr 0x1000; done_o with hit_count_o=1.
- Same entry, line 18 -> row 15; line 19 -> no descriptor, hit_count_o=0. With vflip=1, line 3 -> row 15.
- Entry with y=510, h=0, z=1, line 2 -> row 4 (wrap). The same entry with z=0 -> no hit.
- Entries 1 and 10 both hit, desc_ready_i held low 5 cycles -> descriptor for idx 1 held stable, then idx 10 follows; hit_count_o=2.
- 70 hitting entries, MAX_PER_LINE=64 -> exactly 64 descriptors; overflow_o=1 with SPRITE_LINE_OVERFLOW_EN, 0 without.
- line_start_i mid-scan, and rst_n_i low mid-EMIT -> clean restart from idx 0 / IDLE with all outputs 0; no done_o for the aborted line.
